// File: rtl/cas3_unsort.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cas3_unsort: pairs each sorted triple with a queued permutation tag and  |
// | returns the values to their original a/b/c order.      Rev 1.0           |
// +--------------------------------------------------------------------------+
module cas3_unsort #(
  parameter int SNG_WIDTH = 8,
  parameter int TAG_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tag_valid,
  output logic                         tag_ready,
  input  logic [3:0]                   tag,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SNG_WIDTH-1:0]         in_max,
  input  logic [SNG_WIDTH-1:0]         in_mid,
  input  logic [SNG_WIDTH-1:0]         in_min,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SNG_WIDTH-1:0]         a_out,
  output logic [SNG_WIDTH-1:0]         b_out,
  output logic [SNG_WIDTH-1:0]         c_out,
  output logic                         out_err,
  output logic [$clog2(TAG_DEPTH):0]   tag_count
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(TAG_DEPTH);

  logic [3:0]           tag_mem [TAG_DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic                 push;
  logic                 fire;
  logic [3:0]           head;
  logic [1:0]           max_src;
  logic [1:0]           mid_src;
  logic                 illegal;
  logic [SNG_WIDTH-1:0] nxt_a;
  logic [SNG_WIDTH-1:0] nxt_b;
  logic [SNG_WIDTH-1:0] nxt_c;

  // tag_ready looks only at the registered count, so a same-cycle pop never frees a slot
  assign tag_ready = (tag_count < DEPTH);
  assign in_ready  = (tag_count != '0) && (!out_valid || out_ready);
  assign push      = tag_valid && tag_ready;
  assign fire      = in_valid && in_ready;

  assign head    = tag_mem[rd_ptr];
  assign max_src = head[3:2];
  assign mid_src = head[1:0];
  assign illegal = (max_src == 2'd3) || (mid_src == 2'd3) || (max_src == mid_src);

  function automatic logic [SNG_WIDTH-1:0] pick(
    input logic [1:0]           pos,
    input logic [1:0]           mx_s,
    input logic [1:0]           md_s,
    input logic [SNG_WIDTH-1:0] v_max,
    input logic [SNG_WIDTH-1:0] v_mid,
    input logic [SNG_WIDTH-1:0] v_min
  );
    if (mx_s == pos)      return v_max;
    else if (md_s == pos) return v_mid;
    else                  return v_min;
  endfunction

  always_comb begin
    nxt_a = in_max;
    nxt_b = in_mid;
    nxt_c = in_min;
    if (!illegal) begin
      nxt_a = pick(2'd0, max_src, mid_src, in_max, in_mid, in_min);
      nxt_b = pick(2'd1, max_src, mid_src, in_max, in_mid, in_min);
      nxt_c = pick(2'd2, max_src, mid_src, in_max, in_mid, in_min);
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      tag_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (fire) rd_ptr <= rd_ptr + PW'(1);
      case ({push, fire})
        2'b10:   tag_count <= tag_count + CW'(1);
        2'b01:   tag_count <= tag_count - CW'(1);
        default: tag_count <= tag_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      c_out     <= '0;
      out_err   <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      a_out     <= nxt_a;
      b_out     <= nxt_b;
      c_out     <= nxt_c;
      out_err   <= illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cas3_unsort.sv
`default_nettype none
// Directed bench for cas3_unsort: queue-based reference model checked every
// cycle, plus literal expectations for the hand-worked scenarios.
module tb_cas3_unsort;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tag_valid = 1'b0;
  logic       tag_ready;
  logic [3:0] tag = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_max = '0, in_mid = '0, in_min = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] a_out, b_out, c_out;
  logic       out_err;
  logic [2:0] tag_count;

  int tests = 0;
  int fails = 0;

  cas3_unsort #(.SNG_WIDTH(8), .TAG_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .tag_valid(tag_valid), .tag_ready(tag_ready), .tag(tag),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_max(in_max), .in_mid(in_mid), .in_min(in_min),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out), .c_out(c_out),
    .out_err(out_err), .tag_count(tag_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: tag queue plus the currently presented output beat
  logic [3:0] tq[$];
  bit m_ov = 0;
  int m_a = 0, m_b = 0, m_c = 0;
  bit m_err = 0;

  function automatic void restore(input logic [3:0] t, input int vmax, input int vmid,
                                  input int vmin, output int a, output int b,
                                  output int c, output bit e);
    int v[3];
    int ms, ds;
    ms = int'(t[3:2]);
    ds = int'(t[1:0]);
    if (ms == 3 || ds == 3 || ms == ds) begin
      a = vmax; b = vmid; c = vmin; e = 1;
    end else begin
      v[ms] = vmax;
      v[ds] = vmid;
      v[3 - ms - ds] = vmin;
      a = v[0]; b = v[1]; c = v[2]; e = 0;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tq.delete();
      m_ov = 0; m_a = 0; m_b = 0; m_c = 0; m_err = 0;
    end else begin
      bit can_push, can_join;
      can_push = tq.size() < 4;
      can_join = in_valid && tq.size() != 0 && (!m_ov || out_ready);
      if (can_join) begin
        logic [3:0] t;
        t = tq.pop_front();
        restore(t, int'(in_max), int'(in_mid), int'(in_min), m_a, m_b, m_c, m_err);
        m_ov = 1;
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (tag_valid && can_push) tq.push_back(tag);
    end
  end

  always @(negedge clk) begin
    chk("tag_count", int'(tag_count), tq.size());
    chk("tag_ready", int'(tag_ready), int'(tq.size() < 4));
    chk("in_ready", int'(in_ready), int'(tq.size() != 0 && (!m_ov || out_ready)));
    chk("out_valid", int'(out_valid), int'(m_ov));
    if (m_ov) begin
      chk("a_out", int'(a_out), m_a);
      chk("b_out", int'(b_out), m_b);
      chk("c_out", int'(c_out), m_c);
      chk("out_err", int'(out_err), int'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int mx, input int md, input int mn);
    in_max = 8'(mx); in_mid = 8'(md); in_min = 8'(mn);
  endtask

  task automatic chk_out(input string name, input int a, input int b, input int c, input int e);
    chk({name, ".valid"}, int'(out_valid), 1);
    chk({name, ".a"}, int'(a_out), a);
    chk({name, ".b"}, int'(b_out), b);
    chk({name, ".c"}, int'(c_out), c);
    chk({name, ".err"}, int'(out_err), e);
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    chk("rst.tag_ready", int'(tag_ready), 1);
    chk("rst.in_ready", int'(in_ready), 0);
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.a_out", int'(a_out), 0);
    chk("rst.tag_count", int'(tag_count), 0);
    rst_n = 1'b1;
    cyc();

    // Basic restore: tag b=max, c=mid
    out_ready = 1'b1;
    tag_valid = 1'b1; tag = 4'b0110;
    cyc();
    tag_valid = 1'b0;
    in_valid = 1'b1; set_in(200, 100, 50);
    cyc();
    in_valid = 1'b0;
    chk_out("basic", 50, 200, 100, 0);

    // Identity tag then illegal tag on the same data
    tag_valid = 1'b1; tag = 4'b0001; cyc();
    tag = 4'b0101; cyc();
    tag_valid = 1'b0;
    in_valid = 1'b1; set_in(9, 5, 3);
    cyc();
    chk_out("ident", 9, 5, 3, 0);
    cyc();
    chk_out("illegal", 9, 5, 3, 1);
    in_valid = 1'b0;
    cyc();

    // Fill the tag FIFO; the fifth offer must be refused
    tag_valid = 1'b1;
    tag = 4'b0100; cyc();
    tag = 4'b1000; cyc();
    tag = 4'b1001; cyc();
    tag = 4'b0010; cyc();
    chk("full.tag_ready", int'(tag_ready), 0);
    chk("full.tag_count", int'(tag_count), 4);
    tag = 4'b1111; cyc();
    chk("full.5th", int'(tag_count), 4);
    tag_valid = 1'b0;
    in_valid = 1'b1; set_in(30, 20, 10);
    cyc();
    in_valid = 1'b0;
    chk("join.tag_count", int'(tag_count), 3);
    chk_out("full.join", 20, 30, 10, 0);
    cyc();

    // Backpressure: first beat held while a second triple waits
    out_ready = 1'b0;
    in_valid = 1'b1; set_in(70, 60, 50);
    cyc();
    chk_out("bp.first", 60, 50, 70, 0);
    set_in(80, 40, 20);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp.in_ready", int'(in_ready), 0);
      chk_out("bp.hold", 60, 50, 70, 0);
    end
    out_ready = 1'b1;
    cyc();
    chk_out("bp.next", 20, 40, 80, 0);
    in_valid = 1'b0;
    cyc();
    chk("bp.drop", int'(out_valid), 0);

    // Drain last tag, then in_valid with an empty FIFO
    in_valid = 1'b1; set_in(5, 4, 3);
    cyc();
    chk_out("drain", 5, 3, 4, 0);
    set_in(11, 22, 33);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("empty.in_ready", int'(in_ready), 0);
    end
    tag_valid = 1'b1; tag = 4'b1001;
    #2 chk("nobypass.in_ready", int'(in_ready), 0);
    cyc();
    tag_valid = 1'b0;
    chk("late.in_ready", int'(in_ready), 1);
    cyc();
    in_valid = 1'b0;
    chk_out("late", 33, 22, 11, 0);
    cyc();

    // Asynchronous reset with a held beat and two queued tags
    out_ready = 1'b0;
    tag_valid = 1'b1; tag = 4'b0110; cyc();
    tag_valid = 1'b0;
    in_valid = 1'b1; set_in(1, 2, 3); cyc();
    in_valid = 1'b0;
    tag_valid = 1'b1; tag = 4'b0001; cyc();
    tag = 4'b0010; cyc();
    tag_valid = 1'b0;
    chk("pre_rst.tag_count", int'(tag_count), 2);
    chk("pre_rst.out_valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.tag_count", int'(tag_count), 0);
    chk("arst.out_valid", int'(out_valid), 0);
    chk("arst.a_out", int'(a_out), 0);
    chk("arst.tag_ready", int'(tag_ready), 1);
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tag_valid = 1'b1; tag = 4'b1000; cyc();
    tag_valid = 1'b0;
    in_valid = 1'b1; set_in(7, 8, 9); cyc();
    in_valid = 1'b0;
    chk_out("post_rst", 8, 9, 7, 0);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
